// File: rtl/button_cmd_input.sv
// Push-button front end: synchronise and debounce four buttons, keep a 0-9 digit,
// and issue one-shot write/read commands over a valid/ready handshake.
module button_cmd_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_center,
  input  logic       btn_right,
  input  logic       cmd_ready,
  output logic [3:0] digit,
  output logic       cmd_valid,
  output logic       cmd_write,
  output logic [3:0] cmd_digit
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PEND} state_t;

  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_right, btn_center, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          db_q;
      logic          db_dly_q;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          db_q     <= 1'b0;
          db_dly_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q  <= btn_raw[gi];
          sync2_q  <= sync1_q;
          db_dly_q <= db_q;
          if (sync2_q == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            db_q  <= ~db_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end

      // One-cycle pulse on an accepted press; releases are ignored.
      assign press[gi] = db_q & ~db_dly_q;
    end
  endgenerate

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       cmd_write_q, cmd_write_d;
  logic [3:0] cmd_digit_q, cmd_digit_d;

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cmd_write_d = cmd_write_q;
    cmd_digit_d = cmd_digit_q;

    if (press[0] && !press[1]) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (press[1] && !press[0]) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end

    // Commands capture the digit as it was before any same-cycle edit.
    case (state_q)
      IDLE: begin
        if (press[2]) begin
          state_d     = PEND;
          cmd_write_d = 1'b1;
          cmd_digit_d = digit_q;
        end else if (press[3]) begin
          state_d     = PEND;
          cmd_write_d = 1'b0;
          cmd_digit_d = digit_q;
        end
      end
      PEND: begin
        if (cmd_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      digit_q     <= 4'd0;
      cmd_write_q <= 1'b0;
      cmd_digit_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      cmd_write_q <= cmd_write_d;
      cmd_digit_q <= cmd_digit_d;
    end
  end

  assign digit     = digit_q;
  assign cmd_valid = (state_q == PEND);
  assign cmd_write = cmd_write_q;
  assign cmd_digit = cmd_digit_q;

endmodule

// File: tb/tb_button_cmd_input.sv
// Scoreboard bench for button_cmd_input: stimulus pushes expected digits/commands,
// negedge monitors pop and compare as the DUT presents them.
module tb_button_cmd_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_center = 1'b0;
  logic       btn_right = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [3:0] digit;
  logic       cmd_valid;
  logic       cmd_write;
  logic [3:0] cmd_digit;

  button_cmd_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_center (btn_center),
    .btn_right  (btn_right),
    .cmd_ready  (cmd_ready),
    .digit      (digit),
    .cmd_valid  (cmd_valid),
    .cmd_write  (cmd_write),
    .cmd_digit  (cmd_digit)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int exp_digit_q[$];
  int exp_cmd_q[$];   // write*16 + digit

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitors
  bit mon_en     = 1'b0;
  int last_digit = 0;
  bit prev_valid = 1'b0;
  bit prev_rdy   = 1'b0;
  int cur_cmd    = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        last_digit = int'(digit);
        prev_valid = 1'b0;
      end else begin
        if (int'(digit) != last_digit) begin
          if (exp_digit_q.size() == 0) chk("digit_unexpected", digit, last_digit);
          else chk("digit_seq", digit, exp_digit_q.pop_front());
          last_digit = int'(digit);
        end
        if (cmd_valid && !prev_valid) begin
          if (exp_cmd_q.size() == 0) begin
            chk("cmd_unexpected", cmd_valid, 0);
          end else begin
            cur_cmd = exp_cmd_q.pop_front();
            chk("cmd_write", cmd_write, cur_cmd / 16);
            chk("cmd_digit", cmd_digit, cur_cmd % 16);
          end
        end else if (cmd_valid && prev_valid) begin
          chk("cmd_hold_write", cmd_write, cur_cmd / 16);
          chk("cmd_hold_digit", cmd_digit, cur_cmd % 16);
        end else if (!cmd_valid && prev_valid) begin
          chk("cmd_drop_needs_ready", prev_rdy, 1);
        end
        prev_valid = cmd_valid;
      end
      prev_rdy = cmd_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bits: {right, center, down, up}
  task automatic press(input logic [3:0] m);
    {btn_right, btn_center, btn_down, btn_up} = m;
    tick(D + 3);
    {btn_right, btn_center, btn_down, btn_up} = 4'b0000;
    tick(D + 3);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int up_seq[9];
    int dn_seq[4];
    up_seq = '{2, 3, 4, 5, 6, 7, 8, 9, 0};
    dn_seq = '{8, 7, 6, 5};

    // 1. Asynchronous reset mid-cycle
    #12;
    rst    = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_write", cmd_write, 0);
    chk("rst_cmd_digit", cmd_digit, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post_rst_digit", digit, 0);
    chk("post_rst_valid", cmd_valid, 0);
    chk("post_rst_write", cmd_write, 0);
    chk("post_rst_cmd_digit", cmd_digit, 0);

    // 2. Bounce rejection and exact latency
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      tick(2);
    end
    btn_up = 1'b1;
    exp_digit_q.push_back(1);
    tick(D + 2);
    chk("latency_before", digit, 0);
    tick(1);
    chk("latency_at", digit, 1);
    btn_up = 1'b0;
    tick(D + 3);
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(D + 4);
    chk("glitch_3cyc", digit, 1);

    // 3. Wrap and simultaneous up+down
    for (int i = 0; i < 9; i++) begin
      exp_digit_q.push_back(up_seq[i]);
      press(4'b0001);
    end
    chk("wrap_up", digit, 0);
    exp_digit_q.push_back(9);
    press(4'b0010);
    chk("wrap_down", digit, 9);
    for (int i = 0; i < 4; i++) begin
      exp_digit_q.push_back(dn_seq[i]);
      press(4'b0010);
    end
    press(4'b0011);
    chk("updown_same", digit, 5);

    // 4. Write with backpressure
    exp_digit_q.push_back(6);
    press(4'b0001);
    exp_digit_q.push_back(7);
    press(4'b0001);
    exp_cmd_q.push_back(16 + 7);
    press(4'b0100);
    chk("wr_valid", cmd_valid, 1);
    chk("wr_write", cmd_write, 1);
    chk("wr_digit", cmd_digit, 7);
    press(4'b1000);
    exp_digit_q.push_back(8);
    press(4'b0001);
    chk("pend_valid", cmd_valid, 1);
    chk("pend_cmd_digit", cmd_digit, 7);
    chk("pend_digit_edit", digit, 8);
    accept();
    chk("accept_drop", cmd_valid, 0);

    // 5. Center+right together, then a read
    for (int v = 7; v >= 3; v--) begin
      exp_digit_q.push_back(v);
      press(4'b0010);
    end
    exp_cmd_q.push_back(16 + 3);
    press(4'b1100);
    chk("both_write", cmd_write, 1);
    chk("both_digit", cmd_digit, 3);
    accept();
    chk("both_accept", cmd_valid, 0);
    tick(2);
    exp_cmd_q.push_back(3);
    press(4'b1000);
    chk("rd_valid", cmd_valid, 1);
    chk("rd_write", cmd_write, 0);
    chk("rd_digit", cmd_digit, 3);

    // 6. Reset while a read is pending, center held through release
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pend_valid", cmd_valid, 0);
    chk("rst_pend_digit", digit, 0);
    btn_center = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_cmd_q.push_back(16 + 0);
    tick(D + 2);
    chk("held_press_early", cmd_valid, 0);
    tick(1);
    chk("held_press_valid", cmd_valid, 1);
    chk("held_press_write", cmd_write, 1);
    chk("held_press_digit", cmd_digit, 0);
    accept();
    btn_center = 1'b0;
    tick(D + 4);

    chk("digit_queue_empty", exp_digit_q.size(), 0);
    chk("cmd_queue_empty", exp_cmd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
